// File: rtl/reg_share_arbiter_if.sv
// reg_share_arbiter_if: request/data bundle from the clients and grant/shared-register view back to them.
interface reg_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8
);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] last_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [$clog2(NUM_REQ)-1:0] owner_o;
    logic [DATA_W-1:0] q_o;
    logic q_valid_o;

    modport slave (
        input req_i, last_i, data_i,
        output gnt_o, owner_o, q_o, q_valid_o
    );

    modport master (
        output req_i, last_i, data_i,
        input gnt_o, owner_o, q_o, q_valid_o
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin sharing of one registered data bank between requesters, grants capped at MAX_HOLD.
// Optional macro ARB_PRIO0_EN: requester 0 wins every IDLE arbitration it takes part in.
module reg_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8,
    parameter int MAX_HOLD = 4
) (
    input logic clk,
    input logic reset,
    reg_share_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] ptr_q;
    logic [OW-1:0] sel_d;
    logic [OW-1:0] cand;
    logic found;
    logic [DATA_W-1:0] q_q;
    logic q_valid_q;
    logic [3:0] hold_q;
    logic own_req;
    logic own_last;
    logic hold_end;
    logic [DATA_W-1:0] own_data;

    assign own_req = bus.req_i[owner_q];
    assign own_last = bus.last_i[owner_q];
    assign own_data = DATA_W'(bus.data_i >> (owner_q * DATA_W));
    assign hold_end = hold_q == 4'(MAX_HOLD - 1);

    // Search upward from the requester after the last owner, wrapping at NUM_REQ.
    always_comb begin
        sel_d = ptr_q;
        cand = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == OW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (!found && bus.req_i[cand]) begin
                sel_d = cand;
                found = 1'b1;
            end
        end
`ifdef ARB_PRIO0_EN
        if (bus.req_i[0]) sel_d = '0;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q <= '0;
            owner_q <= '0;
            q_q <= '0;
            q_valid_q <= 1'b0;
            hold_q <= '0;
            ptr_q <= OW'(NUM_REQ - 1);
        end else if (state_q == IDLE) begin
            q_valid_q <= 1'b0;
            if (|bus.req_i) begin
                state_q <= BUSY;
                gnt_q <= NUM_REQ'(1) << sel_d;
                owner_q <= sel_d;
                hold_q <= '0;
            end
        end else begin
            q_valid_q <= own_req;
            if (own_req) begin
                q_q <= own_data;
                hold_q <= hold_q + 4'd1;
            end
            // A dropped request releases just like an end-of-burst or an exhausted hold.
            if (!own_req || own_last || hold_end) begin
                state_q <= IDLE;
                gnt_q <= '0;
                ptr_q <= owner_q;
            end
        end
    end

    assign bus.gnt_o = gnt_q;
    assign bus.owner_o = owner_q;
    assign bus.q_o = q_q;
    assign bus.q_valid_o = q_valid_q;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: directed checks of grant order, hold limit, request drop, reset abort and requester-0 priority.
module tb_reg_share_arbiter;
    logic clk = 1'b0;
    logic reset;
    int n_cmp = 0;
    int n_err = 0;

    reg_share_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    reg_share_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        bus.data_i[k*8 +: 8] = v;
    endtask

    initial begin
        reset = 1'b1;
        bus.req_i = '0;
        bus.last_i = '0;
        bus.data_i = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
        chk("rst_owner", 32'(bus.owner_o), 32'h0);
        chk("rst_q", 32'(bus.q_o), 32'h0);
        chk("rst_qv", 32'(bus.q_valid_o), 32'h0);
        reset = 1'b0;

        // single requester with immediate last
        bus.req_i = 4'b0010;
        bus.last_i = 4'b0010;
        set_data(1, 8'hA5);
        tick();
        chk("single_gnt", 32'(bus.gnt_o), 32'h2);
        chk("single_owner", 32'(bus.owner_o), 32'h1);
        chk("single_qv0", 32'(bus.q_valid_o), 32'h0);
        tick();
        chk("single_q", 32'(bus.q_o), 32'hA5);
        chk("single_qv1", 32'(bus.q_valid_o), 32'h1);
        chk("single_rel", 32'(bus.gnt_o), 32'h0);
        chk("single_owner_hold", 32'(bus.owner_o), 32'h1);
        bus.req_i = '0;
        bus.last_i = '0;
        tick();
        chk("single_idle_qv", 32'(bus.q_valid_o), 32'h0);
        chk("single_idle_q", 32'(bus.q_o), 32'hA5);

        // fairness from reset: owners 0,1,2,3,0 each for four transfers
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("fair_gnt", 32'(bus.gnt_o), 32'(1) << (g % 4));
            chk("fair_owner", 32'(bus.owner_o), 32'(g % 4));
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 4; k++) set_data(k, 8'(8'hF0 + k));
                set_data(g % 4, 8'(8'h10 * (g % 4) + j));
                tick();
                chk("fair_q", 32'(bus.q_o), 32'(8'h10 * (g % 4) + j));
                chk("fair_qv", 32'(bus.q_valid_o), 32'h1);
                chk("fair_gnt_hold", 32'(bus.gnt_o), (j < 3) ? (32'(1) << (g % 4)) : 32'h0);
            end
        end
        bus.req_i = '0;
        tick();
        chk("fair_idle_qv", 32'(bus.q_valid_o), 32'h0);

        // hold limit splits a 6-word burst from requester 2
        bus.req_i = 4'b0100;
        tick();
        chk("hold_gnt", 32'(bus.gnt_o), 32'h4);
        for (int j = 0; j < 4; j++) begin
            set_data(2, 8'(8'h10 + j));
            tick();
            chk("hold_q", 32'(bus.q_o), 32'(8'h10 + j));
            chk("hold_qv", 32'(bus.q_valid_o), 32'h1);
            chk("hold_gnt_seq", 32'(bus.gnt_o), (j < 3) ? 32'h4 : 32'h0);
        end
        set_data(2, 8'h14);
        tick();
        chk("hold_regnt", 32'(bus.gnt_o), 32'h4);
        chk("hold_gap_qv", 32'(bus.q_valid_o), 32'h0);
        chk("hold_gap_q", 32'(bus.q_o), 32'h13);
        tick();
        chk("hold_q14", 32'(bus.q_o), 32'h14);
        set_data(2, 8'h15);
        bus.last_i = 4'b0100;
        tick();
        chk("hold_q15", 32'(bus.q_o), 32'h15);
        chk("hold_last_rel", 32'(bus.gnt_o), 32'h0);
        bus.req_i = '0;
        bus.last_i = '0;
        tick();
        chk("hold_end_gnt", 32'(bus.gnt_o), 32'h0);

        // owner 1 drops its request mid-grant; next search starts above 1
        bus.req_i = 4'b0010;
        tick();
        chk("drop_gnt", 32'(bus.gnt_o), 32'h2);
        bus.req_i = 4'b1001;
        set_data(1, 8'hEE);
        tick();
        chk("drop_qv", 32'(bus.q_valid_o), 32'h0);
        chk("drop_q", 32'(bus.q_o), 32'h15);
        chk("drop_rel", 32'(bus.gnt_o), 32'h0);
        tick();
        chk("drop_next_gnt", 32'(bus.gnt_o), 32'h8);
        chk("drop_next_owner", 32'(bus.owner_o), 32'h3);
        bus.req_i = '0;
        tick();
        chk("drop3_rel", 32'(bus.gnt_o), 32'h0);
        tick();

        // reset in the middle of a burst from requester 0
        bus.req_i = 4'b1111;
        for (int k = 0; k < 4; k++) set_data(k, 8'(8'h60 + k));
        tick();
        chk("rmid_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        tick();
        chk("rmid_q", 32'(bus.q_o), 32'h60);
        chk("rmid_qv", 32'(bus.q_valid_o), 32'h1);
        reset = 1'b1;
        tick();
        chk("rmid_rst_gnt", 32'(bus.gnt_o), 32'h0);
        chk("rmid_rst_q", 32'(bus.q_o), 32'h0);
        chk("rmid_rst_qv", 32'(bus.q_valid_o), 32'h0);
        reset = 1'b0;
        tick();
        chk("rmid_first_gnt", 32'(bus.gnt_o), 32'h1);
        bus.req_i = '0;
        tick();
        chk("rmid_drop_qv", 32'(bus.q_valid_o), 32'h0);
        chk("rmid_drop_gnt", 32'(bus.gnt_o), 32'h0);

        // requester 0 rises during owner 1's grant, pointer at 0
        bus.req_i = 4'b1110;
        set_data(1, 8'h77);
        tick();
        chk("prio_gnt1", 32'(bus.gnt_o), 32'h2);
        bus.req_i = 4'b1111;
        bus.last_i = 4'b0010;
        tick();
        chk("prio_q", 32'(bus.q_o), 32'h77);
        chk("prio_rel", 32'(bus.gnt_o), 32'h0);
        bus.last_i = '0;
        tick();
`ifdef ARB_PRIO0_EN
        chk("prio_next", 32'(bus.gnt_o), 32'h1);
`else
        chk("prio_next", 32'(bus.gnt_o), 32'h4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered data flop bank (the shared register, q_o) between NUM_REQ requesters. It grants one requester at a time and captures that requester's data into the shared register on each transfer cycle. It limits a grant to MAX_HOLD transfers so no requester can starve the others. It sits between client blocks and any downstream logic that consumes a single registered value.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, width of each requester's data and of the shared register
MAX_HOLD, 4, maximum transfers per grant (1..15)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req_i  input  NUM_REQ  per-requester request; held high while the requester has data
last_i  input  NUM_REQ  per-requester end-of-burst marker; qualified by req_i and gnt_o
data_i  input  NUM_REQ*DATA_W  requester data; requester k occupies bits [k*DATA_W +: DATA_W]
gnt_o  output  NUM_REQ  one-hot grant, or all-zero; registered
owner_o  output  $clog2(NUM_REQ)  index of the current or most recent owner; registered
q_o  output  DATA_W  shared register contents
q_valid_o  output  1  one-cycle pulse: q_o was updated at the preceding edge

Behaviour:
- Reset:
  - reset is synchronous and active-high; it is sampled only at posedge clk and overrides all other behaviour.
  - Reset values: state=IDLE, gnt_o=0, owner_o=0, q_o=0, q_valid_o=0, hold count=0, last-owner pointer=NUM_REQ-1 (requester 0 has first priority after reset).
  - Reset asserted mid-burst aborts the burst. No transfer occurs on the reset edge.
- FSM states: IDLE and BUSY.
- IDLE:
  - gnt_o=0.
  - If any req_i bit is high, select the first requester with req_i high, searching from (pointer+1) mod NUM_REQ upward with wrap-around.
  - Next edge: state=BUSY, gnt_o=onehot(sel), owner_o=sel, hold count=0.
  - No requests: stay in IDLE; outputs hold, except q_valid_o=0.
- BUSY, with owner k:
  - Transfer condition: req_i[k]=1.
  - On a transfer edge: q_o<=data_i[k], q_valid_o<=1, hold count increments.
  - Release after a transfer if last_i[k]=1 or hold count==MAX_HOLD-1 (this is the MAX_HOLD-th transfer). On release: next state=IDLE, gnt_o<=0, pointer<=k.
  - If req_i[k]=0 while in BUSY: no transfer; q_o holds; q_valid_o<=0; release as above.
- Latency:
  - Request to grant: 1 cycle.
  - Grant to first q_o update: 1 cycle (q_o changes at the edge after gnt_o rises).
  - Every release inserts exactly one IDLE cycle with gnt_o=0 before the next grant.
- Non-owner inputs are ignored while in BUSY. req_i, last_i and data_i of other requesters never affect q_o.
- q_valid_o is high for at most one cycle per transfer. It is 0 in every cycle that follows an edge without a transfer.
- Simultaneous events:
  - last_i and the hold limit together: a single release.
  - A new request arriving during BUSY is served only after the current release, in round-robin order.
- owner_o holds its value through IDLE until the next grant.

Optional Feature:
Macro ARB_PRIO0_EN.
- Defined: requester 0 is strict priority in IDLE. If req_i[0]=1, requester 0 is granted regardless of the pointer. The pointer is still updated on release. MAX_HOLD still applies.
- Not defined: pure round-robin as above.

Test Plan:
Default parameters (NUM_REQ=4, DATA_W=8, MAX_HOLD=4) unless stated.
- Single requester: req_i=0010, data1=0xA5, last_i[1]=1 at cycle t -> gnt_o=0010 at t+1; at t+2 q_o=0xA5, q_valid_o=1, gnt_o=0000, owner_o=1.
- Fairness: req_i=1111 held, last_i=0 -> grants 0,1,2,3,0. Each grant gives 4 q_valid_o pulses, followed by 1 cycle with gnt_o=0000. q_o tracks data of the current owner.
- Hold limit: only req2 active, 6-word burst 0x10..0x15, last_i on the 6th word -> 4 transfers (0x10..0x13), gnt_o=0 for 1 cycle, regrant to 2, then 0x14, 0x15, release.
- Owner drops request: owner 1 deasserts req_i in BUSY -> no q_valid_o pulse, q_o unchanged, gnt_o=0000 on the next cycle. The next grant goes to the lowest requesting index above 1 (wrap-around).
- Reset mid-burst: assert reset after 2 transfers -> next cycle gnt_o=0, q_o=0x00, q_valid_o=0. With req_i=1111 after reset, the first grant is to requester 0.
- ARB_PRIO0_EN defined: req_i=1110 with pointer=0, then req_i[0] rises during owner 1's burst -> the next grant after release goes to 0, not 2. With the macro undefined, the next grant goes to 2.
